// File: rtl/ncl_dr_source.sv
// ncl_dr_source
//   Clocked-to-NCL boundary source. Buffers binary operand pairs in a small
//   FIFO and presents them to the NCL array as dual-rail DATA/NULL wavefronts.
//   It advances on the array's completion acknowledge, counts delivered
//   tokens and flags a stalled handshake phase.
//
// Ports
//   clk       system clock, all state on rising edge
//   init      synchronous active-high reset (shared with the NCL gate init)
//   in_valid  operand pair offered
//   in_ready  FIFO can accept (not full)
//   in_a      binary operand A, W lanes
//   in_b      binary operand B, W lanes
//   A         dual-rail A, lane i = A[2i+1:2i], 10 = one, 01 = zero, 00 = NULL
//   B         dual-rail B, same encoding
//   ack       asynchronous completion acknowledge (1 = request data, 0 = request null)
//   tokens    completed DATA wavefront count, wraps
//   err       sticky handshake-timeout flag
//
// state  | meaning
// IDLE   | bus NULL, waiting for ack_s=1 and a queued pair
// SEND   | DATA held on bus, waiting for ack_s=0
// RETURN | NULL held on bus, waiting for ack_s=1
module ncl_dr_source #(
  parameter int W       = 1,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           init,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [2*W-1:0] A,
  output logic [2*W-1:0] B,
  input  logic           ack,
  output logic [15:0]    tokens,
  output logic           err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RETURN} state_t;

  function automatic logic [2*W-1:0] dr_enc(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  // ack synchroniser
  logic ack_meta_q, ack_s_q;

  always_ff @(posedge clk) begin
    if (init) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // operand FIFO; pointers carry an extra wrap bit to tell full from empty
  logic [2*W-1:0] mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic           full, empty, push, pop;
  logic [W-1:0]   head_a, head_b;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = in_valid && !full;
  assign in_ready = !full;
  assign {head_a, head_b} = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_a, in_b};
  end

  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // handshake FSM
  state_t         state_q, state_d;
  logic [2*W-1:0] a_q, a_d, b_q, b_d;
  logic [15:0]    tokens_q, tokens_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  always_ff @(posedge clk) begin
    if (init) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      tokens_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tokens_q <= tokens_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    tokens_d = tokens_q;
    err_d    = err_q;
    pop      = 1'b0;
    // saturate at the limit so err stays set without the counter wrapping
    cnt_d    = (cnt_q == CNT_LIM) ? cnt_q : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ack_s_q && !empty) begin
          pop     = 1'b1;
          a_d     = dr_enc(head_a);
          b_d     = dr_enc(head_b);
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (cnt_q == CNT_LIM) err_d = 1'b1;
        if (!ack_s_q) begin
          a_d      = '0;
          b_d      = '0;
          tokens_d = tokens_q + 16'd1;
          cnt_d    = '0;
          state_d  = S_RETURN;
        end
      end
      S_RETURN: begin
        if (cnt_q == CNT_LIM) err_d = 1'b1;
        if (ack_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A      = a_q;
  assign B      = b_q;
  assign tokens = tokens_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ncl_dr_source.sv
module tb_ncl_dr_source;

  localparam int W       = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic           clk = 1'b0;
  logic           init;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a, in_b;
  logic [2*W-1:0] A, B;
  logic           ack;
  logic [15:0]    tokens;
  logic           err;

  ncl_dr_source #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .init(init), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .A(A), .B(B), .ack(ack),
    .tokens(tokens), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  pair_t       q[$];
  logic [15:0] exp_tokens;
  logic        exp_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  // dual-rail value of a binary word: each lane contributes 2 (one) or 1 (zero)
  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < W; i++) r = r + ((v[i] ? 32'd2 : 32'd1) << (2 * i));
    return r[2*W-1:0];
  endfunction

  function automatic logic bus_legal(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    logic ok;
    ok = 1'b1;
    if (a == 0 && b == 0) return 1'b1;
    for (int i = 0; i < W; i++) begin
      if (!(a[2*i+:2] == 2'b01 || a[2*i+:2] == 2'b10)) ok = 1'b0;
      if (!(b[2*i+:2] == 2'b01 || b[2*i+:2] == 2'b10)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one clock with the reference model updated from the observed bus edges
  task automatic tick();
    logic [2*W-1:0] pa, pb;
    pair_t p;
    pa = A;
    pb = B;
    @(posedge clk);
    #1;
    check("rail_legal", {31'd0, bus_legal(A, B)}, 32'd1);
    if (pa == 0 && A != 0) begin
      if (q.size() == 0) begin
        check("unexpected_data", {28'd0, A}, 32'd0);
      end else begin
        p = q.pop_front();
        check("data_A", {28'd0, A}, {28'd0, enc(p.a)});
        check("data_B", {28'd0, B}, {28'd0, enc(p.b)});
      end
    end else if (pa != 0 && A != 0) begin
      check("hold_A", {28'd0, A}, {28'd0, pa});
      check("hold_B", {28'd0, B}, {28'd0, pb});
    end
    if (pa != 0 && A == 0) exp_tokens = exp_tokens + 16'd1;
    check("tokens", {16'd0, tokens}, {16'd0, exp_tokens});
    check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < DEPTH)});
    check("err", {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    if (q.size() < DEPTH) q.push_back(p);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_data(input string tag);
    for (int k = 0; k < 30 && A == 0; k++) tick();
    check(tag, {31'd0, (A != 0)}, 32'd1);
  endtask

  // act as the consuming stage for one token
  task automatic serve(input int d_fall, input int d_rise);
    wait_data("data_wait");
    repeat (d_fall) tick();
    ack = 1'b0;
    tick();
    tick();
    check("null_not_early", {31'd0, (A != 0)}, 32'd1);
    tick();
    check("null_latency", {28'd0, A}, 32'd0);
    repeat (d_rise) tick();
    ack = 1'b1;
  endtask

  task automatic do_reset(input logic ack_val);
    init = 1'b1;
    ack = ack_val;
    repeat (3) @(posedge clk);
    #1;
    q.delete();
    exp_tokens = 16'd0;
    exp_err = 1'b0;
    init = 1'b0;
  endtask

  initial begin
    init = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    ack = 1'b1;
    exp_tokens = 16'd0;
    exp_err = 1'b0;

    // reset values
    do_reset(1'b1);
    check("rst_A", {28'd0, A}, 32'd0);
    check("rst_B", {28'd0, B}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_tokens", {16'd0, tokens}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // ack low: FIFO fills, nothing driven, fifth push dropped
    ack = 1'b0;
    for (int i = 0; i < 4; i++) push(W'($urandom), W'($urandom));
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    push(W'($urandom), W'($urandom));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_no_data", {28'd0, A}, 32'd0);
    end

    // back-to-back drain of the four queued pairs
    ack = 1'b1;
    for (int i = 0; i < 4; i++) serve(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    repeat (12) tick();
    check("b2b_tokens", {16'd0, tokens}, 32'd4);
    check("b2b_drained", {28'd0, A}, 32'd0);

    // single token with push-to-DATA latency
    push(2'b01, 2'b10);
    check("latency_t1", {28'd0, A}, 32'd0);
    tick();
    check("latency_t2_A", {28'd0, A}, {28'd0, enc(2'b01)});
    check("latency_t2_B", {28'd0, B}, {28'd0, enc(2'b10)});
    serve(4, 4);
    repeat (6) tick();
    check("single_tokens", {16'd0, tokens}, 32'd5);

    // stall in SEND: err exactly 16 cycles after DATA
    push(2'b11, 2'b00);
    wait_data("stall_data");
    repeat (TIMEOUT - 1) tick();
    exp_err = 1'b1;
    tick();
    repeat (3) tick();
    check("stall_still_data", {31'd0, (A != 0)}, 32'd1);
    ack = 1'b0;
    repeat (3) tick();
    check("stall_null", {28'd0, A}, 32'd0);
    check("stall_tokens", {16'd0, tokens}, 32'd6);
    ack = 1'b1;
    repeat (6) tick();

    // randomized rounds against the queue model
    for (int r = 0; r < 12; r++) begin
      ack = 1'($urandom);
      for (int n = int'($urandom_range(1, 5)); n > 0; n--) begin
        if ($urandom_range(0, 3) == 0) tick();
        push(W'($urandom), W'($urandom));
      end
      ack = 1'b1;
      for (int k = 0; k < 8 && (q.size() > 0 || A != 0); k++)
        serve(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      repeat (6) tick();
      check("round_drained", q.size(), 32'd0);
    end

    // counter wrap
    force dut.tokens_q = 16'hFFFF;
    exp_tokens = 16'hFFFF;
    tick();
    release dut.tokens_q;
    tick();
    push(2'b10, 2'b01);
    serve(1, 1);
    repeat (6) tick();
    check("wrap_tokens", {16'd0, tokens}, 32'd0);

    // init during SEND with two pairs still queued
    ack = 1'b0;
    for (int i = 0; i < 3; i++) push(W'($urandom), W'($urandom));
    ack = 1'b1;
    wait_data("midrst_data");
    init = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_A", {28'd0, A}, 32'd0);
    check("midrst_B", {28'd0, B}, 32'd0);
    @(posedge clk);
    #1;
    init = 1'b0;
    q.delete();
    exp_tokens = 16'd0;
    exp_err = 1'b0;
    check("midrst_tokens", {16'd0, tokens}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_err", {31'd0, err}, 32'd0);
    repeat (10) tick();
    check("midrst_flushed", {28'd0, A}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
